// File: rtl/bt656_tx_ctrl_pkg.sv
// Shared definitions for the bt656_tx run-time sequencer: state codes, config
// record and the standard timing presets also used by bt656_tx benches.
package bt656_tx_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_ARM    = 3'd3;
  localparam logic [2:0] ST_RUN    = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;

  typedef struct packed {
    logic        interlace;
    logic        first_field;
    logic [15:0] first_line;
  } cfg_t;

  typedef struct packed {
    logic [11:0] h_active;
    logic [11:0] h_blank;
    logic [10:0] v_active;
    logic [10:0] v_blank;
    logic        interlace;
    logic        first_field;
    logic [15:0] first_line;
  } timing_t;

  localparam timing_t PRESET_PAL  = '{h_active: 12'd720,  h_blank: 12'd144,
                                      v_active: 11'd576,  v_blank: 11'd49,
                                      interlace: 1'b1, first_field: 1'b0,
                                      first_line: 16'd23};
  localparam timing_t PRESET_NTSC = '{h_active: 12'd720,  h_blank: 12'd138,
                                      v_active: 11'd487,  v_blank: 11'd38,
                                      interlace: 1'b1, first_field: 1'b1,
                                      first_line: 16'd20};
  localparam timing_t PRESET_720P = '{h_active: 12'd1280, h_blank: 12'd370,
                                      v_active: 11'd720,  v_blank: 11'd30,
                                      interlace: 1'b0, first_field: 1'b0,
                                      first_line: 16'd26};

endpackage

// File: rtl/bt656_vedge.sv
// Registers the bt656_tx V output and emits registered rise/fall pulses.
module bt656_vedge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic v_i,
  output logic rise_o,
  output logic fall_o
);
  logic v_q, rise_q, fall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      v_q    <= v_i;
      rise_q <= v_i & ~v_q;
      fall_q <= ~v_i & v_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/bt656_tx_ctrl.sv
// Run-time sequencer for bt656_tx: shadowed config applied only while the
// transmitter is disabled, frame-counted or continuous runs, V-edge watchdog.
module bt656_tx_ctrl
  import bt656_tx_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1200000,
  parameter int FRAME_W        = 16
) (
  input  logic               i_SysClock,
  input  logic               i_ResetN,
  input  logic               i_Start,
  input  logic               i_Stop,
  input  logic [FRAME_W-1:0] i_FrameCount,
  input  logic               i_CfgLoad,
  input  logic               i_CfgInterlace,
  input  logic               i_CfgFirstField,
  input  logic [15:0]        i_CfgFirstLine,
  input  logic               i_Vsignal,
  output logic               o_TxValid,
  output logic               o_InterlaceMode,
  output logic               o_FirstField,
  output logic [15:0]        o_FirstLine,
  output logic               o_Busy,
  output logic               o_Done,
  output logic [FRAME_W-1:0] o_FramesSent,
  output logic               o_Error
);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]         state_q, state_d;
  cfg_t               shadow_q, shadow_d, cfg_q, cfg_d;
  logic [FRAME_W-1:0] tgt_q, tgt_d, frames_q, frames_d, frames_inc;
  logic               txv_q, txv_d, done_q, done_d, err_q, err_d;
  logic               reload_q, reload_d, stop_q, stop_d, field_q, field_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [TO_W-1:0]    wd_q, wd_d;
  logic               vrise, vfall, live, frame_end, target_hit, wd_fire;

  bt656_vedge u_vedge (
    .clk_i  (i_SysClock),
    .rst_ni (i_ResetN),
    .v_i    (i_Vsignal),
    .rise_o (vrise),
    .fall_o (vfall)
  );

  always_comb begin
    live       = (state_q == ST_ARM) || (state_q == ST_RUN);
    frames_inc = (&frames_q) ? frames_q : frames_q + 1'b1;
    // In interlace mode a frame ends on the second field's V rise.
    frame_end  = (state_q == ST_RUN) && vrise && (!cfg_q.interlace || field_q);
    target_hit = (tgt_q != '0) && (frames_inc == tgt_q);
    wd_fire    = live && !(vrise || vfall) && (wd_q == TO_LAST);
    wd_d       = (live && !(vrise || vfall)) ? wd_q + 1'b1 : '0;
  end

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    tgt_d    = tgt_q;
    frames_d = frames_q;
    txv_d    = txv_q;
    err_d    = err_q;
    reload_d = reload_q;
    stop_d   = stop_q;
    field_d  = field_q;
    settle_d = settle_q;
    shadow_d = shadow_q;
    if (i_CfgLoad) begin
      shadow_d = '{interlace: i_CfgInterlace, first_field: i_CfgFirstField,
                   first_line: i_CfgFirstLine};
    end
    case (state_q)
      ST_IDLE: begin
        txv_d = 1'b0;
        if (i_Start) begin
          state_d  = ST_LOAD;
          tgt_d    = i_FrameCount;
          frames_d = '0;
          err_d    = 1'b0;
        end
      end
      ST_LOAD: begin
        cfg_d    = shadow_q;
        reload_d = 1'b0;
        settle_d = '0;
        state_d  = i_Stop ? ST_STOP : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (i_Stop) begin
          state_d = ST_STOP;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = ST_ARM;
          txv_d   = 1'b1;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_ARM: begin
        if (i_Stop) begin
          state_d = ST_STOP;
          txv_d   = 1'b0;
        end else if (vfall) begin
          state_d = ST_RUN;
          field_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (i_Stop)                     stop_d   = 1'b1;
        if (i_CfgLoad)                  reload_d = 1'b1;
        if (vrise && cfg_q.interlace)   field_d  = ~field_q;
        if (frame_end) begin
          frames_d = frames_inc;
          if (stop_q || target_hit) begin
            state_d  = ST_STOP;
            txv_d    = 1'b0;
            reload_d = 1'b0;
            stop_d   = 1'b0;
          end else if (reload_q) begin
            state_d = ST_LOAD;
            txv_d   = 1'b0;
          end
        end
      end
      ST_STOP: begin
        txv_d   = 1'b0;
        stop_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        txv_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    if (wd_fire) begin
      err_d    = 1'b1;
      txv_d    = 1'b0;
      stop_d   = 1'b0;
      reload_d = 1'b0;
      state_d  = ST_IDLE;
    end
    done_d = (state_d == ST_STOP);
  end

  always_ff @(posedge i_SysClock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      cfg_q    <= '0;
      tgt_q    <= '0;
      frames_q <= '0;
      txv_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      reload_q <= 1'b0;
      stop_q   <= 1'b0;
      field_q  <= 1'b0;
      settle_q <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      tgt_q    <= tgt_d;
      frames_q <= frames_d;
      txv_q    <= txv_d;
      done_q   <= done_d;
      err_q    <= err_d;
      reload_q <= reload_d;
      stop_q   <= stop_d;
      field_q  <= field_d;
      settle_q <= settle_d;
      wd_q     <= wd_d;
    end
  end

  assign o_TxValid       = txv_q;
  assign o_InterlaceMode = cfg_q.interlace;
  assign o_FirstField    = cfg_q.first_field;
  assign o_FirstLine     = cfg_q.first_line;
  assign o_Busy          = (state_q != ST_IDLE);
  assign o_Done          = done_q;
  assign o_FramesSent    = frames_q;
  assign o_Error         = err_q;
endmodule

// File: tb/tb_bt656_tx_ctrl.sv
// Bench for bt656_tx_ctrl: a behavioural V generator stands in for bt656_tx and
// scenario tasks compare the sequencer against expectations derived from its rules.
module tb_bt656_tx_ctrl;
  import bt656_tx_ctrl_pkg::*;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 1000;
  localparam int FW      = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0;
  logic [FW-1:0] fcount = '0;
  logic          cfg_load = 1'b0, cfg_il = 1'b0, cfg_ff = 1'b0;
  logic [15:0]   cfg_fl = '0;
  logic          vsig = 1'b1;
  logic          txv, il, ff, busy, done, err;
  logic [15:0]   fl;
  logic [FW-1:0] fsent;

  bt656_tx_ctrl #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT), .FRAME_W(FW)) dut (
    .i_SysClock(clk), .i_ResetN(rst_n), .i_Start(start), .i_Stop(stop),
    .i_FrameCount(fcount), .i_CfgLoad(cfg_load), .i_CfgInterlace(cfg_il),
    .i_CfgFirstField(cfg_ff), .i_CfgFirstLine(cfg_fl), .i_Vsignal(vsig),
    .o_TxValid(txv), .o_InterlaceMode(il), .o_FirstField(ff), .o_FirstLine(fl),
    .o_Busy(busy), .o_Done(done), .o_FramesSent(fsent), .o_Error(err)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  int gA = 200, gB = 40, gen_cnt = 0;
  bit vhold0 = 1'b0;
  bit txv_prev, err_prev, v_prev;
  int rise_cyc, fall_cyc, err_cyc, vrise_en, vrise_set_cyc, fall_vrises;
  int done_cnt, txv_rises, start_cyc;

  task automatic clear_mon();
    txv_prev = txv; err_prev = err; v_prev = vsig;
    rise_cyc = -1; fall_cyc = -1; err_cyc = -1; vrise_en = 0; vrise_set_cyc = -1;
    fall_vrises = -1; done_cnt = 0; txv_rises = 0;
  endtask

  // One clock: observe outputs after the edge, then advance the V generator,
  // which sits in vertical blanking (V high) whenever TxValid is low.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (txv && !txv_prev) begin rise_cyc = cyc; txv_rises++; end
    if (!txv && txv_prev) begin fall_cyc = cyc; fall_vrises = vrise_en; end
    txv_prev = txv;
    if (err && !err_prev) err_cyc = cyc;
    err_prev = err;
    if (done) done_cnt++;
    if (vhold0) vsig = 1'b0;
    else if (!txv) begin gen_cnt = 0; vsig = 1'b1; end
    else begin vsig = ((gen_cnt % (gA + gB)) < gB); gen_cnt++; end
    if (vsig && !v_prev && txv) begin vrise_en++; vrise_set_cyc = cyc; end
    v_prev = vsig;
  endtask

  task automatic load_cfg(input bit i_il, input bit i_ff, input logic [15:0] i_fl);
    cfg_il = i_il; cfg_ff = i_ff; cfg_fl = i_fl; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic start_run(input int n, input bit with_stop);
    fcount = FW'(n); start = 1'b1; stop = with_stop;
    tick();
    start = 1'b0; stop = 1'b0; start_cyc = cyc;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic run_to_idle(input int budget, output bit to);
    for (int i = 0; i < budget && busy; i++) tick();
    to = busy;
  endtask

  task automatic wait_run(output bit to);
    int i;
    for (i = 0; i < 2000 && !(txv && vsig == 1'b0); i++) tick();
    to = !(txv && vsig == 1'b0);
    repeat (5) tick();
  endtask

  task automatic new_gen();
    gA = $urandom_range(100, 300);
    gB = $urandom_range(20, 60);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({txv, il, ff, fl, busy, done, fsent, err} !== '0) begin
      fails++; $display("FAIL reset_hold: outputs=%h required 0", {txv, il, ff, fl, busy, done, fsent, err});
    end
    rst_n = 1'b1;
    tick(); tick();
    tests++;
    if ({txv, il, ff, fl, busy, done, fsent, err} !== '0) begin
      fails++; $display("FAIL reset_release: outputs=%h required 0", {txv, il, ff, fl, busy, done, fsent, err});
    end
  endtask

  task automatic test_progressive();
    logic [15:0] l_fl = 16'($urandom);
    bit l_ff = 1'($urandom);
    bit to;
    new_gen();
    load_cfg(1'b0, l_ff, l_fl);
    clear_mon();
    start_run(3, 1'b0);
    tick();
    tests++;
    if ({il, ff, fl} !== {1'b0, l_ff, l_fl}) begin
      fails++; $display("FAIL prog_cfg_apply: got %h required %h", {il, ff, fl}, {1'b0, l_ff, l_fl});
    end
    run_to_idle(6000, to);
    tests++;
    if (to) begin fails++; $display("FAIL prog_timeout: still busy=%0b required 0", busy); end
    tests++;
    if (rise_cyc - start_cyc != SETTLE + 1) begin
      fails++; $display("FAIL prog_enable_latency: got %0d required %0d", rise_cyc - start_cyc, SETTLE + 1);
    end
    tests++;
    if (vrise_en != 3) begin fails++; $display("FAIL prog_vrise_count: got %0d required 3", vrise_en); end
    tests++;
    if (fsent !== FW'(3)) begin fails++; $display("FAIL prog_frames: got %0d required 3", fsent); end
    tests++;
    if (done_cnt != 1) begin fails++; $display("FAIL prog_done: got %0d required 1", done_cnt); end
    tests++;
    if (fall_cyc - vrise_set_cyc != 2) begin
      fails++; $display("FAIL prog_fall_latency: got %0d required 2", fall_cyc - vrise_set_cyc);
    end
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL prog_error: got %0b required 0", err); end
  endtask

  task automatic test_interlace();
    bit to;
    new_gen();
    load_cfg(PRESET_PAL.interlace, PRESET_PAL.first_field, PRESET_PAL.first_line);
    clear_mon();
    start_run(1, 1'b0);
    run_to_idle(4000, to);
    tests++;
    if (to) begin fails++; $display("FAIL il_timeout: still busy=%0b required 0", busy); end
    tests++;
    if (fall_vrises != 2) begin fails++; $display("FAIL il_fall_on_vrise: got %0d required 2", fall_vrises); end
    tests++;
    if (fall_cyc - vrise_set_cyc != 2) begin
      fails++; $display("FAIL il_fall_latency: got %0d required 2", fall_cyc - vrise_set_cyc);
    end
    tests++;
    if ({fsent, il, fl} !== {FW'(1), 1'b1, PRESET_PAL.first_line}) begin
      fails++; $display("FAIL il_frames_cfg: got %h required %h", {fsent, il, fl}, {FW'(1), 1'b1, PRESET_PAL.first_line});
    end
    tests++;
    if (done_cnt != 1) begin fails++; $display("FAIL il_done: got %0d required 1", done_cnt); end
  endtask

  task automatic test_reload();
    logic [15:0] old_fl = 16'h0100 | 16'($urandom_range(0, 255));
    int fr_at_fall;
    bit to;
    new_gen();
    load_cfg(1'b0, 1'b0, old_fl);
    clear_mon();
    start_run(0, 1'b0);
    for (int i = 0; i < 3000 && !(vrise_en >= 2 && vsig == 1'b0); i++) tick();
    repeat (3) tick();
    cfg_fl = 16'd5; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    tests++;
    if ({txv, fl} !== {1'b1, old_fl}) begin
      fails++; $display("FAIL reload_shadow_hidden: got %h required %h", {txv, fl}, {1'b1, old_fl});
    end
    fall_cyc = -1;
    for (int i = 0; i < 1000 && fall_cyc < 0; i++) tick();
    fr_at_fall = vrise_en;
    tests++;
    if (fall_cyc < 0 || fl !== old_fl || fsent !== FW'(fr_at_fall)) begin
      fails++; $display("FAIL reload_frame_end: fall=%0d fl=%0d frames=%0d required fl=%0d frames=%0d",
                        fall_cyc, fl, fsent, old_fl, fr_at_fall);
    end
    rise_cyc = -1;
    for (int i = 0; i < 100 && rise_cyc < 0; i++) tick();
    tests++;
    if (rise_cyc - fall_cyc != SETTLE + 1) begin
      fails++; $display("FAIL reload_gap: got %0d required %0d", rise_cyc - fall_cyc, SETTLE + 1);
    end
    tests++;
    if ({fl, fsent} !== {16'd5, FW'(fr_at_fall)}) begin
      fails++; $display("FAIL reload_applied: got %h required %h", {fl, fsent}, {16'd5, FW'(fr_at_fall)});
    end
    pulse_stop();
    run_to_idle(200, to);
    tests++;
    if (to || done_cnt != 1) begin
      fails++; $display("FAIL reload_stop: busy=%0b done=%0d required busy=0 done=1", busy, done_cnt);
    end
  endtask

  task automatic test_stop_and_load();
    logic [15:0] old_fl = 16'h0200 | 16'($urandom_range(0, 255));
    logic [15:0] new_fl = 16'h0400 | 16'($urandom_range(0, 255));
    bit to;
    new_gen();
    load_cfg(1'b0, 1'b1, old_fl);
    clear_mon();
    start_run(0, 1'b0);
    wait_run(to);
    tests++;
    if (to) begin fails++; $display("FAIL sl_reach_run: txv=%0b v=%0b required 1/0", txv, vsig); end
    cfg_il = 1'b0; cfg_ff = 1'b0; cfg_fl = new_fl; cfg_load = 1'b1; stop = 1'b1;
    tick();
    cfg_load = 1'b0; stop = 1'b0;
    run_to_idle(2000, to);
    tests++;
    if (to || done_cnt != 1 || txv_rises != 1) begin
      fails++; $display("FAIL sl_single_stop: busy=%0b done=%0d enables=%0d required 0/1/1", busy, done_cnt, txv_rises);
    end
    tests++;
    if ({fl, fsent} !== {old_fl, FW'(1)}) begin
      fails++; $display("FAIL sl_no_load: got %h required %h", {fl, fsent}, {old_fl, FW'(1)});
    end
    clear_mon();
    start_run(0, 1'b1);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL start_wins: busy=%0b required 1", busy); end
    tick();
    tests++;
    if ({ff, fl} !== {1'b0, new_fl}) begin
      fails++; $display("FAIL sl_shadow_kept: got %h required %h", {ff, fl}, {1'b0, new_fl});
    end
    for (int i = 0; i < 100 && rise_cyc < 0; i++) tick();
    tests++;
    if (rise_cyc - start_cyc != SETTLE + 1) begin
      fails++; $display("FAIL start_stop_latency: got %0d required %0d", rise_cyc - start_cyc, SETTLE + 1);
    end
    pulse_stop();
    run_to_idle(100, to);
    tests++;
    if (to || done_cnt != 1) begin
      fails++; $display("FAIL sl_arm_stop: busy=%0b done=%0d required 0/1", busy, done_cnt);
    end
  endtask

  task automatic test_timeout();
    bit to;
    vhold0 = 1'b1;
    repeat (3) tick();
    clear_mon();
    start_run(2, 1'b0);
    for (int i = 0; i < TIMEOUT + 200 && err_cyc < 0; i++) tick();
    repeat (5) tick();
    tests++;
    if (err_cyc < 0 || err_cyc - rise_cyc != TIMEOUT) begin
      fails++; $display("FAIL wd_latency: got %0d required %0d", err_cyc - rise_cyc, TIMEOUT);
    end
    tests++;
    if ({err, txv, busy} !== 3'b100 || done_cnt != 0) begin
      fails++; $display("FAIL wd_state: err/txv/busy=%b done=%0d required 100 done=0", {err, txv, busy}, done_cnt);
    end
    start_run(2, 1'b0);
    tests++;
    if ({err, busy} !== 2'b01) begin
      fails++; $display("FAIL wd_clear_on_start: err/busy=%b required 01", {err, busy});
    end
    pulse_stop();
    run_to_idle(100, to);
    tests++;
    if (to || done_cnt != 1) begin
      fails++; $display("FAIL wd_restart_stop: busy=%0b done=%0d required 0/1", busy, done_cnt);
    end
    vhold0 = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    bit to;
    new_gen();
    load_cfg(1'b1, 1'b1, 16'h0800 | 16'($urandom_range(1, 255)));
    clear_mon();
    start_run(0, 1'b0);
    wait_run(to);
    #4;
    rst_n = 1'b0;
    #1;
    tests++;
    if (to || {txv, il, ff, fl, busy, done, fsent, err} !== '0) begin
      fails++; $display("FAIL async_reset: outputs=%h required 0", {txv, il, ff, fl, busy, done, fsent, err});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    tests++;
    if ({busy, txv} !== 2'b00) begin fails++; $display("FAIL reset_idle: busy/txv=%b required 00", {busy, txv}); end
    clear_mon();
    start_run(0, 1'b0);
    tick();
    tests++;
    if ({il, ff, fl} !== '0) begin
      fails++; $display("FAIL reset_shadow: got %h required 0", {il, ff, fl});
    end
    pulse_stop();
    run_to_idle(100, to);
    tests++;
    if (to || done_cnt != 1) begin
      fails++; $display("FAIL reset_restart_stop: busy=%0b done=%0d required 0/1", busy, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_progressive();
    test_interlace();
    test_reload();
    test_stop_and_load();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end
endmodule
